// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator CPU micro-sequencer: opcodes, control
// bit positions, ALU operations and sequencer states.
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_AND    = 8'h08;
    localparam logic [7:0] OP_OR     = 8'h09;

    localparam int C0 = 0;  // MBR[7:0] -> PC
    localparam int C1 = 1;  // PC -> MBR (reserved)
    localparam int C2 = 2;  // PC -> MAR, PC+1
    localparam int C3 = 3;  // memory read into MBR
    localparam int C4 = 4;  // MBR -> IR
    localparam int C5 = 5;  // IR addr -> MAR
    localparam int C6 = 6;  // ACC -> MBR
    localparam int C7 = 7;  // memory write
    localparam int C8 = 8;  // MBR -> BR
    localparam int C9 = 9;  // ACC <= ALU result

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_EXEC1, S_EXEC2, S_EXEC3, S_EXEC4, S_HALTED
    } state_e;

    function automatic logic op_legal(input logic [7:0] op);
        return op <= OP_OR;
    endfunction

    function automatic alu_op_e alu_of(input logic [7:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory strobe waits on ready; flags expiry on the cycle the
// count would reach the limit. A zero limit never expires.
module mem_wait_timer #(
    parameter int TW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_wait,
    input  logic [TW-1:0] i_limit,
    output logic          o_expired
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt_q <= '0;
        else if (i_clear)
            cnt_q <= '0;
        else if (i_wait && cnt_q != '1)
            cnt_q <= cnt_q + TW'(1);
    end

    assign o_expired = i_wait && (i_limit != '0) &&
                       (({1'b0, cnt_q} + (TW+1)'(1)) == {1'b0, i_limit});

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute micro-sequencer. State and flags are registered; the
// control word is decoded from state and the latched opcode.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CW          = 10,
    parameter int OPW         = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_halt_req,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_acc_neg,
    input  logic           i_mem_ready,
    output logic [CW-1:0]  o_ctrl,
    output logic [2:0]     o_alu_op,
    output logic           o_busy,
    output logic           o_halted,
    output logic           o_illegal,
    output logic           o_bus_err,
    output logic           o_instr_done
);

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e         state_q;
    logic [OPW-1:0] op_q;
    logic           illegal_q, bus_err_q;

    logic           is_store, is_jump, mem_state, expired;
    state_e         bound_d;
    logic [CW-1:0]  ctrl_d;
    alu_op_e        alu_d;
    logic           done_d;

    assign is_store  = (op_q == OP_STORE);
    assign is_jump   = (op_q == OP_JMP) || (op_q == OP_JMPGEZ);
    assign mem_state = (state_q == S_FETCH2) ||
                       (state_q == S_EXEC2 && !is_store) ||
                       (state_q == S_EXEC3 && is_store);
    assign bound_d   = i_halt_req ? S_HALTED : S_FETCH1;

    mem_wait_timer #(.TW(TW)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (!mem_state || i_mem_ready),
        .i_wait    (mem_state && !i_mem_ready),
        .i_limit   (TW'(MEM_TIMEOUT)),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:   if (i_start) state_q <= S_FETCH1;
                S_FETCH1: state_q <= S_FETCH2;
                S_FETCH2: begin
                    if (expired) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else if (i_mem_ready) begin
                        state_q <= S_FETCH3;
                    end
                end
                S_FETCH3: state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= i_opcode;
                    if (i_opcode == OP_NOP)
                        state_q <= bound_d;
                    else if (i_opcode == OP_HALT)
                        state_q <= S_HALTED;
                    else if (!op_legal(i_opcode)) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else
                        state_q <= S_EXEC1;
                end
                S_EXEC1:  state_q <= is_jump ? bound_d : S_EXEC2;
                S_EXEC2: begin
                    if (is_store)
                        state_q <= S_EXEC3;
                    else if (expired) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else if (i_mem_ready)
                        state_q <= S_EXEC3;
                end
                S_EXEC3: begin
                    if (!is_store)
                        state_q <= S_EXEC4;
                    else if (expired) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else if (i_mem_ready)
                        state_q <= bound_d;
                end
                S_EXEC4:  state_q <= bound_d;
                S_HALTED: begin
                    if (i_start) begin
                        illegal_q <= 1'b0;
                        bus_err_q <= 1'b0;
                        state_q   <= S_FETCH1;
                    end
                end
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // A memory-write instruction only finishes on the cycle ready is seen.
    always_comb begin
        ctrl_d = '0;
        alu_d  = ALU_PASS;
        done_d = 1'b0;
        case (state_q)
            S_FETCH1: ctrl_d[C2] = 1'b1;
            S_FETCH2: ctrl_d[C3] = 1'b1;
            S_FETCH3: ctrl_d[C4] = 1'b1;
            S_DECODE: done_d = (i_opcode == OP_NOP) || (i_opcode == OP_HALT);
            S_EXEC1: begin
                if (op_q == OP_JMP) begin
                    ctrl_d[C0] = 1'b1;
                    done_d     = 1'b1;
                end else if (op_q == OP_JMPGEZ) begin
                    ctrl_d[C0] = !i_acc_neg;
                    done_d     = 1'b1;
                end else
                    ctrl_d[C5] = 1'b1;
            end
            S_EXEC2: begin
                if (is_store) ctrl_d[C6] = 1'b1;
                else          ctrl_d[C3] = 1'b1;
            end
            S_EXEC3: begin
                if (is_store) begin
                    ctrl_d[C7] = 1'b1;
                    done_d     = i_mem_ready;
                end else
                    ctrl_d[C8] = 1'b1;
            end
            S_EXEC4: begin
                ctrl_d[C9] = 1'b1;
                alu_d      = alu_of(op_q);
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_ctrl       = ctrl_d;
    assign o_alu_op     = alu_d;
    assign o_instr_done = done_d;
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign o_halted     = (state_q == S_HALTED);
    assign o_illegal    = illegal_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// trace, which is popped and compared cycle by cycle.
module tb_cpu_control_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst, i_start, i_halt_req, i_acc_neg, i_mem_ready;
    logic [7:0] i_opcode;
    logic [9:0] o_ctrl;
    logic [2:0] o_alu_op;
    logic       o_busy, o_halted, o_illegal, o_bus_err, o_instr_done;

    typedef struct {
        logic [9:0] ctrl;
        logic       done;
        logic [2:0] alu;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    cpu_control_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_halt_req   (i_halt_req),
        .i_opcode     (i_opcode),
        .i_acc_neg    (i_acc_neg),
        .i_mem_ready  (i_mem_ready),
        .o_ctrl       (o_ctrl),
        .o_alu_op     (o_alu_op),
        .o_busy       (o_busy),
        .o_halted     (o_halted),
        .o_illegal    (o_illegal),
        .o_bus_err    (o_bus_err),
        .o_instr_done (o_instr_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [9:0] c, input logic d, input logic [2:0] a);
        exp_t e;
        e.ctrl = c;
        e.done = d;
        e.alu  = a;
        sb.push_back(e);
    endtask

    task automatic push_instr(input logic [7:0] op, input logic neg);
        push(10'h004, 1'b0, 3'd0);
        push(10'h008, 1'b0, 3'd0);
        push(10'h010, 1'b0, 3'd0);
        push(10'h000, (op == 8'h00) || (op == 8'h07), 3'd0);
        case (op)
            8'h02, 8'h03, 8'h04, 8'h08, 8'h09: begin
                push(10'h020, 1'b0, 3'd0);
                push(10'h008, 1'b0, 3'd0);
                push(10'h100, 1'b0, 3'd0);
                case (op)
                    8'h03:   push(10'h200, 1'b1, 3'd1);
                    8'h04:   push(10'h200, 1'b1, 3'd2);
                    8'h08:   push(10'h200, 1'b1, 3'd3);
                    8'h09:   push(10'h200, 1'b1, 3'd4);
                    default: push(10'h200, 1'b1, 3'd0);
                endcase
            end
            8'h01: begin
                push(10'h020, 1'b0, 3'd0);
                push(10'h040, 1'b0, 3'd0);
                push(10'h080, 1'b1, 3'd0);
            end
            8'h06: push(10'h001, 1'b1, 3'd0);
            8'h05: push(neg ? 10'h000 : 10'h001, 1'b1, 3'd0);
            default: ;
        endcase
    endtask

    // Starts in FETCH1; h_on/h_off are trace indices at which halt_req is raised/dropped.
    task automatic run_instr(input logic [7:0] op, input logic neg, input int h_on,
                             input int h_off, input logic exp_halt);
        exp_t e;
        int   idx;
        idx = 0;
        i_opcode  = op;
        i_acc_neg = neg;
        push_instr(op, neg);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (idx == h_on)  i_halt_req = 1'b1;
            if (idx == h_off) i_halt_req = 1'b0;
            chk($sformatf("op%0h_ctrl[%0d]", op, idx), 32'(o_ctrl), 32'(e.ctrl));
            chk($sformatf("op%0h_done[%0d]", op, idx), 32'(o_instr_done), 32'(e.done));
            chk($sformatf("op%0h_alu[%0d]", op, idx), 32'(o_alu_op), 32'(e.alu));
            step();
            idx++;
        end
        chk($sformatf("op%0h_post_ctrl", op), 32'(o_ctrl), exp_halt ? 32'h0 : 32'h4);
        chk($sformatf("op%0h_post_halted", op), 32'(o_halted), 32'(exp_halt));
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_halt_req = 1'b0;
        i_acc_neg = 1'b0; i_mem_ready = 1'b1; i_opcode = 8'h00;
        #3;
        chk("rst_ctrl", 32'(o_ctrl), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_halted", 32'(o_halted), 0);
        chk("rst_illegal", 32'(o_illegal), 0);
        chk("rst_bus_err", 32'(o_bus_err), 0);
        chk("rst_done", 32'(o_instr_done), 0);
        step();
        i_rst = 1'b0;
        step();
        chk("idle_ctrl", 32'(o_ctrl), 0);
        chk("idle_busy", 32'(o_busy), 0);
        pulse_start();
        chk("start_ctrl", 32'(o_ctrl), 32'h004);
        chk("start_busy", 32'(o_busy), 1);

        run_instr(8'h02, 1'b0, -1, -1, 1'b0);
        run_instr(8'h03, 1'b0, -1, -1, 1'b0);
        run_instr(8'h04, 1'b0, -1, -1, 1'b0);
        run_instr(8'h08, 1'b0, -1, -1, 1'b0);
        run_instr(8'h09, 1'b0, -1, -1, 1'b0);
        run_instr(8'h01, 1'b0, -1, -1, 1'b0);
        run_instr(8'h00, 1'b0, -1, -1, 1'b0);
        run_instr(8'h06, 1'b0, -1, -1, 1'b0);
        run_instr(8'h05, 1'b1, -1, -1, 1'b0);
        run_instr(8'h05, 1'b0, -1, -1, 1'b0);

        // Fetch with three wait cycles
        i_opcode = 8'h00;
        i_mem_ready = 1'b0;
        step();
        chk("w3_c1", 32'(o_ctrl), 32'h008);
        step();
        chk("w3_c2", 32'(o_ctrl), 32'h008);
        step();
        chk("w3_c3", 32'(o_ctrl), 32'h008);
        step();
        chk("w3_c4", 32'(o_ctrl), 32'h008);
        i_mem_ready = 1'b1;
        step();
        chk("w3_fetch3", 32'(o_ctrl), 32'h010);
        chk("w3_bus_err", 32'(o_bus_err), 0);
        step();
        chk("w3_decode_done", 32'(o_instr_done), 1);
        step();
        chk("w3_next", 32'(o_ctrl), 32'h004);

        // Fetch timeout after 15 waiting cycles
        i_mem_ready = 1'b0;
        step();
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("to_wait[%0d]", k), 32'(o_ctrl), 32'h008);
            chk($sformatf("to_err[%0d]", k), 32'(o_bus_err), 0);
            step();
        end
        chk("to_bus_err", 32'(o_bus_err), 1);
        chk("to_halted", 32'(o_halted), 1);
        chk("to_busy", 32'(o_busy), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("to_hold_ctrl[%0d]", k), 32'(o_ctrl), 0);
            step();
        end
        i_mem_ready = 1'b1;
        pulse_start();
        chk("restart_bus_err", 32'(o_bus_err), 0);
        chk("restart_halted", 32'(o_halted), 0);
        chk("restart_ctrl", 32'(o_ctrl), 32'h004);

        // Illegal opcode
        run_instr(8'hFF, 1'b0, -1, -1, 1'b1);
        chk("ill_flag", 32'(o_illegal), 1);
        pulse_start();
        chk("ill_clear", 32'(o_illegal), 0);
        chk("ill_restart", 32'(o_ctrl), 32'h004);

        // Halt raised in EXEC2 of ADD, then a request dropped before the boundary
        run_instr(8'h03, 1'b0, 5, -1, 1'b1);
        i_halt_req = 1'b0;
        pulse_start();
        chk("halt_restart", 32'(o_ctrl), 32'h004);
        run_instr(8'h04, 1'b0, 4, 5, 1'b0);
        run_instr(8'h07, 1'b0, -1, -1, 1'b1);
        pulse_start();
        chk("haltop_restart", 32'(o_ctrl), 32'h004);

        // Reset during STORE memory write
        i_opcode = 8'h01;
        for (int k = 0; k < 5; k++) step();
        i_mem_ready = 1'b0;
        step();
        chk("st_exec3", 32'(o_ctrl), 32'h080);
        chk("st_exec3_done", 32'(o_instr_done), 0);
        #1 i_rst = 1'b1;
        #1;
        chk("mrst_ctrl", 32'(o_ctrl), 0);
        chk("mrst_busy", 32'(o_busy), 0);
        chk("mrst_done", 32'(o_instr_done), 0);
        step();
        i_rst = 1'b0;
        i_mem_ready = 1'b1;
        step();
        chk("mrst_idle", 32'(o_ctrl), 0);
        chk("mrst_halted", 32'(o_halted), 0);

        // Start and halt together from IDLE
        i_halt_req = 1'b1;
        pulse_start();
        chk("sh_ctrl", 32'(o_ctrl), 32'h004);
        run_instr(8'h00, 1'b0, -1, -1, 1'b1);
        i_halt_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
